// File: rtl/count_strobe_gen.sv
// Push-button to count/deCount strobe generator: sync, debounce, edge-detect, hold-to-repeat.
// Latency: first strobe SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after the key edge; all outputs registered.
// Backpressure: none; strobes are single-cycle fire-and-forget pulses.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   key_up_n    raw up button, asynchronous, 0 = pressed
//   key_down_n  raw down button, asynchronous, 0 = pressed
//   count       one-cycle increment strobe
//   deCount     one-cycle decrement strobe
//   up_held     debounced up-button level, 1 = pressed
//   down_held   debounced down-button level, 1 = pressed
module count_strobe_gen #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_up_n,
    input  logic key_down_n,
    output logic count,
    output logic deCount,
    output logic up_held,
    output logic down_held
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1: the flip happens on the
    // cycle that would take it to DEBOUNCE_CYCLES.
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_DELAY   = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] T_PERIOD  = TMR_W'(REPEAT_PERIOD);
    localparam bit               REPEAT_ON = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UP_HOLD   = 2'd1,
        DOWN_HOLD = 2'd2,
        LOCKOUT   = 2'd3
    } state_t;

    // Index 0 = up button, index 1 = down button.
    logic [1:0]             key_n;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [SYNC_STAGES-1:0] sync_d [2];
    logic [CNT_W-1:0]       cnt_q  [2];
    logic [CNT_W-1:0]       cnt_d  [2];
    logic [1:0]             pressed;
    logic [1:0]             lvl_q;
    logic [1:0]             lvl_d;
    logic [1:0]             lvl_prev_q;
    logic [1:0]             press_ev;

    state_t                 state_q;
    state_t                 state_d;
    logic [TMR_W-1:0]       timer_q;
    logic [TMR_W-1:0]       timer_d;
    logic                   count_q;
    logic                   count_d;
    logic                   decount_q;
    logic                   decount_d;

    logic up_lvl;
    logic dn_lvl;
    logic up_ev;
    logic dn_ev;

    assign key_n    = {key_down_n, key_up_n};
    assign pressed  = ~{sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    // A press event is visible for exactly the one cycle after the debounced level rises.
    assign press_ev = lvl_q & ~lvl_prev_q;

    assign up_lvl = lvl_q[0];
    assign dn_lvl = lvl_q[1];
    assign up_ev  = press_ev[0];
    assign dn_ev  = press_ev[1];

    //------------------------------------------------------------------
    // Synchroniser + debounce
    //------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            sync_d[b] = {sync_q[b][SYNC_STAGES-2:0], key_n[b]};
            lvl_d[b]  = lvl_q[b];
            cnt_d[b]  = '0;
            if (pressed[b] != lvl_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    lvl_d[b] = ~lvl_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                sync_q[b] <= '1;
                cnt_q[b]  <= '0;
            end
            lvl_q      <= '0;
            lvl_prev_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                sync_q[b] <= sync_d[b];
                cnt_q[b]  <= cnt_d[b];
            end
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
        end
    end

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= 1'b0;
            decount_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            decount_q <= decount_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (up_lvl && dn_lvl) begin
                    state_d = LOCKOUT;
                end else if (up_ev) begin
                    state_d = UP_HOLD;
                end else if (dn_ev) begin
                    state_d = DOWN_HOLD;
                end
            end
            UP_HOLD: begin
                if (!up_lvl) begin
                    state_d = IDLE;
                end else if (dn_lvl) begin
                    state_d = LOCKOUT;
                end
            end
            DOWN_HOLD: begin
                if (!dn_lvl) begin
                    state_d = IDLE;
                end else if (up_lvl) begin
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (!up_lvl && !dn_lvl) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs and repeat timer
    // Strobes are only produced when the state is staying put (or leaving IDLE
    // for a HOLD), so no strobe coincides with leaving a HOLD state.
    //------------------------------------------------------------------
    always_comb begin
        count_d   = 1'b0;
        decount_d = 1'b0;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                if (!(up_lvl && dn_lvl)) begin
                    if (up_ev) begin
                        count_d = 1'b1;
                        timer_d = T_DELAY;
                    end else if (dn_ev) begin
                        decount_d = 1'b1;
                        timer_d   = T_DELAY;
                    end
                end
            end
            UP_HOLD: begin
                if (REPEAT_ON && up_lvl && !dn_lvl) begin
                    // Reload on the step that would hit zero, so the timer never wraps.
                    if (timer_q <= TMR_W'(1)) begin
                        count_d = 1'b1;
                        timer_d = T_PERIOD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            DOWN_HOLD: begin
                if (REPEAT_ON && dn_lvl && !up_lvl) begin
                    if (timer_q <= TMR_W'(1)) begin
                        decount_d = 1'b1;
                        timer_d   = T_PERIOD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            default: timer_d = '0;
        endcase
    end

    assign count     = count_q;
    assign deCount   = decount_q;
    assign up_held   = lvl_q[0];
    assign down_held = lvl_q[1];

endmodule

// File: tb/tb_count_strobe_gen.sv
// Testbench for count_strobe_gen: scoreboard of expected strobe edges and kinds.
// Inputs are driven 2 time units after a rising edge; the monitor samples on the falling edge.
// Edge numbering: edge_n counts rising clock edges since time 0.
module tb_count_strobe_gen;

    localparam int SYNC   = 2;
    localparam int DB     = 16;
    localparam int RDLY   = 64;
    localparam int RPER   = 16;
    localparam int DB_LAT = SYNC + DB;   // edge (after the drive edge) where the debounced level flips
    localparam int LAT    = DB_LAT + 1;  // edge where the strobe rises

    logic clk;
    logic reset_n;
    logic key_up_n;
    logic key_down_n;
    logic count;
    logic deCount;
    logic up_held;
    logic down_held;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int e;
        bit up;
    } exp_t;

    exp_t sb[$];

    count_strobe_gen #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_up_n  (key_up_n),
        .key_down_n(key_down_n),
        .count     (count),
        .deCount   (deCount),
        .up_held   (up_held),
        .down_held (down_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic goto(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_strobe(input int e, input bit up);
        exp_t x;
        x.e  = e;
        x.up = up;
        sb.push_back(x);
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (count || deCount) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe_edge", edge_n, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("strobe_edge", edge_n, x.e);
                check("strobe_kind", {30'd0, count, deCount}, x.up ? 32'd2 : 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p;
        int t1;

        reset_n    = 1'b0;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_count", count, 0);
        check("rst_deCount", deCount, 0);
        check("rst_up_held", up_held, 0);
        check("rst_down_held", down_held, 0);
        reset_n = 1'b1;
        goto(edge_n + 5);

        // 1: single up press, 40 cycles, no repeat
        t0 = edge_n;
        key_up_n = 1'b0;
        expect_strobe(t0 + LAT, 1'b1);
        goto(t0 + DB_LAT - 1);
        check("t1_up_held_pre", up_held, 0);
        goto(t0 + DB_LAT);
        check("t1_up_held_on", up_held, 1);
        goto(t0 + 40);
        key_up_n = 1'b1;
        goto(t0 + 40 + DB_LAT - 1);
        check("t1_up_held_still", up_held, 1);
        goto(t0 + 40 + DB_LAT);
        check("t1_up_held_off", up_held, 0);
        goto(t0 + 100);
        check("t1_sb_empty", sb.size(), 0);

        // 2: 10-cycle glitch on down is rejected
        t0 = edge_n;
        key_down_n = 1'b0;
        goto(t0 + 10);
        key_down_n = 1'b1;
        goto(t0 + 15);
        check("t2_down_held_mid", down_held, 0);
        goto(t0 + 40);
        check("t2_down_held_end", down_held, 0);
        check("t2_sb_empty", sb.size(), 0);

        // 3: down held with auto-repeat, debounced release at P+120
        t0 = edge_n;
        p  = t0 + LAT;
        key_down_n = 1'b0;
        expect_strobe(p, 1'b0);
        expect_strobe(p + RDLY, 1'b0);
        expect_strobe(p + RDLY + RPER, 1'b0);
        expect_strobe(p + RDLY + 2 * RPER, 1'b0);
        expect_strobe(p + RDLY + 3 * RPER, 1'b0);
        goto(p + 120 - DB_LAT);
        key_down_n = 1'b1;
        goto(p + 119);
        check("t3_down_held_on", down_held, 1);
        goto(p + 120);
        check("t3_down_held_off", down_held, 0);
        goto(p + 150);
        check("t3_sb_empty", sb.size(), 0);

        // 4: both pressed together -> lockout; later a clean down press strobes once
        t0 = edge_n;
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        goto(t0 + DB_LAT);
        check("t4_up_held", up_held, 1);
        check("t4_down_held", down_held, 1);
        goto(t0 + 40);
        key_up_n = 1'b1;
        goto(t0 + 100);
        check("t4_up_rel", up_held, 0);
        check("t4_down_still", down_held, 1);
        check("t4_no_strobe", sb.size(), 0);
        key_down_n = 1'b1;
        goto(t0 + 130);
        check("t4_down_rel", down_held, 0);
        key_down_n = 1'b0;
        expect_strobe(t0 + 130 + LAT, 1'b0);
        goto(t0 + 160);
        key_down_n = 1'b1;
        goto(t0 + 200);
        check("t4_sb_empty", sb.size(), 0);

        // 5: up held, down joins 30 cycles after P -> lockout suppresses repeat
        t0 = edge_n;
        p  = t0 + LAT;
        key_up_n = 1'b0;
        expect_strobe(p, 1'b1);
        goto(p + 30);
        key_down_n = 1'b0;
        goto(p + 30 + DB_LAT);
        check("t5_down_held", down_held, 1);
        goto(p + 100);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        goto(p + 140);
        check("t5_sb_empty", sb.size(), 0);

        // 6: reset mid-hold, key still held at deassertion
        t0 = edge_n;
        p  = t0 + LAT;
        key_up_n = 1'b0;
        expect_strobe(p, 1'b1);
        expect_strobe(p + RDLY, 1'b1);
        goto(p + 69);
        check("t6_up_held_pre", up_held, 1);
        goto(p + 70);
        reset_n = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_up_held", up_held, 0);
        check("t6_sb_mid", sb.size(), 0);
        goto(p + 73);
        reset_n = 1'b1;
        t1 = edge_n;
        expect_strobe(t1 + LAT, 1'b1);
        goto(t1 + DB_LAT - 1);
        check("t6_up_held_pre2", up_held, 0);
        goto(t1 + DB_LAT);
        check("t6_up_held_on2", up_held, 1);
        goto(t1 + 40);
        key_up_n = 1'b1;
        goto(t1 + 80);
        check("t6_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
